// File: rtl/sumrest_display_decoder.sv
// sumrest_display_decoder
// Captures the 4-bit add/subtract unit result on a load strobe.
// Decodes it into a signed decimal value.
// Drives a 4-digit multiplexed common-anode 7-segment display (active-low).
module sumrest_display_decoder #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] sumt,
  input  logic       ct,
  input  logic       sign,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       neg
);

  // A one-cycle dwell still needs a 1-bit counter so the compare below stays legal.
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  // Capture registers
  logic [3:0]       r_sumt_q, r_sumt_d;
  logic             r_ct_q, r_ct_d;
  logic             r_sign_q, r_sign_d;

  // Scan state
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;

  // Registered display outputs
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             neg_q, neg_d;

  // Decode results
  logic [4:0]       mag;
  logic             negative;
  logic             show_minus;
  logic [1:0]       tens;
  logic [4:0]       tens_x10;
  logic [3:0]       ones;

  // Maps a decimal digit to its active-low {g,f,e,d,c,b,a} pattern.
  function automatic logic [6:0] seg_code(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Capture the operation result on load; otherwise hold.
  always_comb begin
    r_sumt_d = r_sumt_q;
    r_ct_d   = r_ct_q;
    r_sign_d = r_sign_q;
    if (load) begin
      r_sumt_d = sumt;
      r_ct_d   = ct;
      r_sign_d = sign;
    end
  end

  // Refresh counter and digit index; the index steps on the counter wrap.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Interpret the captured result as magnitude plus sign, then split it into decimal digits.
  always_comb begin
    mag      = {r_ct_q, r_sumt_q};
    negative = 1'b0;
    if (r_sign_q) begin
      if (r_ct_q) begin
        // No borrow: the difference is the raw 4-bit result.
        mag = {1'b0, r_sumt_q};
      end else begin
        // Borrow: the result is the two's complement of the magnitude.
        mag      = {1'b0, ~r_sumt_q + 4'd1};
        negative = 1'b1;
      end
    end
    // A borrow with a zero result wraps to magnitude 0, which never gets a minus.
    show_minus = negative && (mag != 5'd0);

    // The magnitude is at most 31, so the tens digit is found by range compares.
    if (mag >= 5'd30) begin
      tens     = 2'd3;
      tens_x10 = 5'd30;
    end else if (mag >= 5'd20) begin
      tens     = 2'd2;
      tens_x10 = 5'd20;
    end else if (mag >= 5'd10) begin
      tens     = 2'd1;
      tens_x10 = 5'd10;
    end else begin
      tens     = 2'd0;
      tens_x10 = 5'd0;
    end
    ones = 4'(mag - tens_x10);
  end

  // Select the anode and segment pattern for the digit currently being scanned.
  always_comb begin
    an_d  = 4'b1110;
    seg_d = SEG_BLANK;
    neg_d = show_minus;
    case (idx_q)
      2'd0: begin
        an_d  = 4'b1110;
        seg_d = seg_code(ones);
      end
      2'd1: begin
        an_d  = 4'b1101;
        seg_d = (tens == 2'd0) ? SEG_BLANK : seg_code({2'b00, tens});
      end
      2'd2: begin
        an_d  = 4'b1011;
        seg_d = SEG_BLANK;
      end
      default: begin
        an_d  = 4'b0111;
        seg_d = show_minus ? SEG_MINUS : SEG_BLANK;
      end
    endcase
  end

  // All state updates on the clock; reset aborts scan and capture immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sumt_q <= 4'd0;
      r_ct_q   <= 1'b0;
      r_sign_q <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      seg_q    <= SEG_ZERO;
      an_q     <= 4'b1110;
      neg_q    <= 1'b0;
    end else begin
      r_sumt_q <= r_sumt_d;
      r_ct_q   <= r_ct_d;
      r_sign_q <= r_sign_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      neg_q    <= neg_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign neg = neg_q;

endmodule

// File: tb/tb_sumrest_display_decoder.sv
// Directed bench for sumrest_display_decoder with a small reference model.
// It also keeps a scoreboard queue of expected observations.
module tb_sumrest_display_decoder;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [3:0] sumt = 4'd0;
  logic       ct = 1'b0;
  logic       sign = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       neg;

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] exp_q[$];
  string       tag_q[$];

  sumrest_display_decoder #(.REFRESH_DIV(DIV)) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .sumt (sumt),
    .ct   (ct),
    .sign (sign),
    .seg  (seg),
    .an   (an),
    .neg  (neg)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] digit_seg(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected {an, seg, neg} for digit d, from a signed-integer view of the result.
  function automatic logic [11:0] model(input logic s, input logic c, input logic [3:0] t, input int d);
    int mag;
    logic ng;
    logic [6:0] sg;
    logic [3:0] a;
    ng = 1'b0;
    if (!s) mag = (c ? 16 : 0) + int'(t);
    else if (c) mag = int'(t);
    else begin
      mag = (16 - int'(t)) % 16;
      ng  = (mag != 0);
    end
    case (d)
      0: begin a = 4'b1110; sg = digit_seg(mag % 10); end
      1: begin a = 4'b1101; sg = (mag >= 10) ? digit_seg(mag / 10) : 7'b1111111; end
      2: begin a = 4'b1011; sg = 7'b1111111; end
      default: begin a = 4'b0111; sg = ng ? 7'b0111111 : 7'b1111111; end
    endcase
    return {a, sg, ng};
  endfunction

  task automatic push(input string tag, input logic [11:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic pop_cmp(input logic [11:0] obs);
    logic [11:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_cmp++;
    assert (obs === e) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", t, obs, e);
    end
    $display("cmp %s obs=%h exp=%h", t, obs, e);
  endtask

  task automatic do_load(input logic s, input logic c, input logic [3:0] t);
    @(negedge clk);
    sign = s; ct = c; sumt = t; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Walk digits 0..3 and compare each against the model once it is displayed.
  task automatic check_frame(input string name, input logic s, input logic c, input logic [3:0] t);
    logic [11:0] e;
    int waited;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      e = model(s, c, t, d);
      push($sformatf("%s_d%0d", name, d), e);
      waited = 0;
      while (an !== e[11:8] && waited < 40) begin
        @(negedge clk);
        waited++;
      end
      pop_cmp({an, seg, neg});
    end
  endtask

  initial begin
    logic [3:0] seq [0:4];
    int len;
    int waited;
    seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111; seq[4] = 4'b1110;

    // Reset state
    repeat (3) @(negedge clk);
    push("reset_state", {4'b1110, 7'b1000000, 1'b0});
    pop_cmp({an, seg, neg});
    rst = 1'b0;

    // Add 27
    do_load(1'b0, 1'b1, 4'b1011);
    check_frame("add27", 1'b0, 1'b1, 4'b1011);

    // Load latency: captured at edge k, visible at edge k+1
    @(negedge clk);
    sign = 1'b1; ct = 1'b0; sumt = 4'b1101; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    push("lat_edge_k", 12'(1'b0));
    pop_cmp(12'(neg));
    @(negedge clk);
    push("lat_edge_k1", 12'(1'b1));
    pop_cmp(12'(neg));

    // Subtract -3
    check_frame("sub_m3", 1'b1, 1'b0, 4'b1101);

    // Subtract zero (no borrow) and borrow with zero result
    do_load(1'b1, 1'b1, 4'b0000);
    check_frame("sub_zero", 1'b1, 1'b1, 4'b0000);
    do_load(1'b1, 1'b0, 4'b0000);
    check_frame("sub_borrow0", 1'b1, 1'b0, 4'b0000);

    // Subtract -15
    do_load(1'b1, 1'b0, 4'b0001);
    check_frame("sub_m15", 1'b1, 1'b0, 4'b0001);

    // Inputs ignored while load is low
    @(negedge clk);
    sign = 1'b0; ct = 1'b1; sumt = 4'b0111;
    repeat (3) @(negedge clk);
    check_frame("hold", 1'b1, 1'b0, 4'b0001);

    // Load held for three cycles: the last sample wins
    @(negedge clk);
    sign = 1'b0; ct = 1'b1; sumt = 4'b0011; load = 1'b1;
    @(negedge clk);
    sumt = 4'b0110;
    @(negedge clk);
    sumt = 4'b1001;
    @(negedge clk);
    load = 1'b0;
    check_frame("multi_load", 1'b0, 1'b1, 4'b1001);

    // Asynchronous reset while digit 2 is active
    waited = 0;
    while (an !== 4'b1011 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    push("pre_reset_idx2", {4'b1011, 1'b0});
    pop_cmp({an, 1'b0});
    #2 rst = 1'b1;
    #1;
    push("async_reset", {4'b1110, 7'b1000000, 1'b0});
    pop_cmp({an, seg, neg});
    @(negedge clk);
    rst = 1'b0;

    // Scan order and dwell after reset release
    @(negedge clk);
    for (int r = 0; r < 4; r++) begin
      len = 0;
      while (an === seq[r] && len < 10) begin
        push($sformatf("onehot_r%0d", r), 12'd1);
        pop_cmp(12'($countones(~an)));
        len++;
        @(negedge clk);
      end
      push($sformatf("dwell_r%0d", r), 12'(DIV));
      pop_cmp(12'(len));
    end
    push("scan_wrap", {8'd0, seq[4]});
    pop_cmp({8'd0, an});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected summary");
    $fatal(1, "timeout");
  end

endmodule
